// File: rtl/cpu_branch_ctrl.sv
// Multi-cycle sequencer for the ARM-subset CPU: decodes IR and NZCV and drives
// every datapath strobe and mux select. Only the state is registered.
module cpu_branch_ctrl #(
    parameter bit EN_BL = 1'b1,
    parameter int ST_W  = 3
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic [31:0]     I,
    input  logic [3:0]      NZCV,
    output logic            Write_PC,
    output logic            Write_IR,
    output logic            Write_Reg,
    output logic            LA,
    output logic            LB,
    output logic            LC,
    output logic            LF,
    output logic            S,
    output logic            rm_imm_s,
    output logic [1:0]      rs_imm_s,
    output logic [3:0]      ALU_OP,
    output logic [2:0]      SHIFT_OP,
    output logic [1:0]      PC_s,
    output logic            rd_s,
    output logic            ALU_A_s,
    output logic            ALU_B_s,
    output logic [ST_W-1:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WB      = 3'd4,
        ST_LINK    = 3'd5,
        ST_LINK_WB = 3'd6,
        ST_BRANCH  = 3'd7
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   cond_pass_s;
    logic   dp_legal_s;
    logic   unused_s;

    // ARM condition-code table evaluated on {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: return z;
            4'b0001: return ~z;
            4'b0010: return c;
            4'b0011: return ~c;
            4'b0100: return n;
            4'b0101: return ~n;
            4'b0110: return v;
            4'b0111: return ~v;
            4'b1000: return c & ~z;
            4'b1001: return ~c | z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return ~z & (n == v);
            4'b1101: return z | (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign cond_pass_s = cond_pass(I[31:28], NZCV);
    // Register-form DP with I[7]=I[4]=1 is the multiply/extra space: not handled here.
    assign dp_legal_s  = (I[27:26] == 2'b00) && !(!I[25] && I[4] && I[7]);
    assign state       = ST_W'(state_r);
    assign unused_s    = ^{I[19:8], I[3:0]};

    // State register with synchronous reset that abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and output decode from state and IR.
    always_comb begin
        state_nxt_s = ST_IDLE;
        Write_PC    = 1'b0;
        Write_IR    = 1'b0;
        Write_Reg   = 1'b0;
        LA          = 1'b0;
        LB          = 1'b0;
        LC          = 1'b0;
        LF          = 1'b0;
        S           = 1'b0;
        rm_imm_s    = 1'b0;
        rs_imm_s    = 2'b00;
        ALU_OP      = 4'b0000;
        SHIFT_OP    = 3'b000;
        PC_s        = 2'b00;
        rd_s        = 1'b0;
        ALU_A_s     = 1'b0;
        ALU_B_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                Write_IR    = 1'b1;
                Write_PC    = 1'b1;
                PC_s        = 2'b00;
                state_nxt_s = ST_DECODE;
            end
            ST_DECODE: begin
                LA = 1'b1;
                LB = 1'b1;
                LC = 1'b1;
                if (!cond_pass_s) begin
                    state_nxt_s = ST_FETCH;
                end else if (dp_legal_s) begin
                    state_nxt_s = ST_EXEC;
                end else if (I[27:25] == 3'b101) begin
                    state_nxt_s = (I[24] && EN_BL) ? ST_LINK : ST_BRANCH;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                LF     = 1'b1;
                ALU_OP = I[24:21];
                S      = I[20];
                if (I[25]) begin
                    rm_imm_s = 1'b1;
                    rs_imm_s = 2'b10;
                    SHIFT_OP = 3'b111;
                end else if (!I[4]) begin
                    rm_imm_s = 1'b0;
                    rs_imm_s = 2'b01;
                    SHIFT_OP = {I[6:5], 1'b0};
                end else begin
                    rm_imm_s = 1'b0;
                    rs_imm_s = 2'b00;
                    SHIFT_OP = {I[6:5], 1'b1};
                end
                // TST/TEQ/CMP/CMN only update flags, so skip write-back.
                state_nxt_s = (I[24:23] == 2'b10) ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                Write_Reg   = 1'b1;
                rd_s        = 1'b0;
                state_nxt_s = ST_FETCH;
            end
            ST_LINK: begin
                // PC already holds instr+4, so PC + 0 gives the return address.
                LF          = 1'b1;
                ALU_A_s     = 1'b1;
                ALU_B_s     = 1'b1;
                ALU_OP      = 4'b0100;
                S           = 1'b0;
                state_nxt_s = ST_LINK_WB;
            end
            ST_LINK_WB: begin
                Write_Reg   = 1'b1;
                rd_s        = 1'b1;
                Write_PC    = 1'b1;
                PC_s        = 2'b01;
                state_nxt_s = ST_FETCH;
            end
            ST_BRANCH: begin
                Write_PC    = 1'b1;
                PC_s        = 2'b01;
                state_nxt_s = ST_FETCH;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_branch_ctrl.sv
// Directed bench for cpu_branch_ctrl: walks instruction sequences cycle by cycle
// and compares state plus every control output against hand-derived values.
module tb_cpu_branch_ctrl;

    logic        clk = 1'b0;
    logic        Rst;
    logic [31:0] I;
    logic [3:0]  NZCV;

    logic Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S, rm_imm_s, rd_s, ALU_A_s, ALU_B_s;
    logic [1:0] rs_imm_s, PC_s;
    logic [3:0] ALU_OP;
    logic [2:0] SHIFT_OP, state;

    logic n_Write_PC, n_Write_IR, n_Write_Reg, n_LA, n_LB, n_LC, n_LF, n_S, n_rm_imm_s, n_rd_s, n_ALU_A_s, n_ALU_B_s;
    logic [1:0] n_rs_imm_s, n_PC_s;
    logic [3:0] n_ALU_OP;
    logic [2:0] n_SHIFT_OP, n_state;

    logic [22:0] ctl, n_ctl;
    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    cpu_branch_ctrl #(.EN_BL(1'b1), .ST_W(3)) u_dut (
        .clk(clk), .Rst(Rst), .I(I), .NZCV(NZCV),
        .Write_PC(Write_PC), .Write_IR(Write_IR), .Write_Reg(Write_Reg),
        .LA(LA), .LB(LB), .LC(LC), .LF(LF), .S(S),
        .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .ALU_OP(ALU_OP), .SHIFT_OP(SHIFT_OP),
        .PC_s(PC_s), .rd_s(rd_s), .ALU_A_s(ALU_A_s), .ALU_B_s(ALU_B_s), .state(state)
    );

    cpu_branch_ctrl #(.EN_BL(1'b0), .ST_W(3)) u_dut_nb (
        .clk(clk), .Rst(Rst), .I(I), .NZCV(NZCV),
        .Write_PC(n_Write_PC), .Write_IR(n_Write_IR), .Write_Reg(n_Write_Reg),
        .LA(n_LA), .LB(n_LB), .LC(n_LC), .LF(n_LF), .S(n_S),
        .rm_imm_s(n_rm_imm_s), .rs_imm_s(n_rs_imm_s), .ALU_OP(n_ALU_OP), .SHIFT_OP(n_SHIFT_OP),
        .PC_s(n_PC_s), .rd_s(n_rd_s), .ALU_A_s(n_ALU_A_s), .ALU_B_s(n_ALU_B_s), .state(n_state)
    );

    assign ctl = {Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S, rm_imm_s, rs_imm_s,
                  ALU_OP, SHIFT_OP, PC_s, rd_s, ALU_A_s, ALU_B_s};
    assign n_ctl = {n_Write_PC, n_Write_IR, n_Write_Reg, n_LA, n_LB, n_LC, n_LF, n_S, n_rm_imm_s,
                    n_rs_imm_s, n_ALU_OP, n_SHIFT_OP, n_PC_s, n_rd_s, n_ALU_A_s, n_ALU_B_s};

    function automatic logic [22:0] pk(input logic wpc, wir, wreg, la, lb, lc, lf, s, rm,
                                       input logic [1:0] rs, input logic [3:0] aop,
                                       input logic [2:0] sop, input logic [1:0] pcs,
                                       input logic rd, aa, ab);
        return {wpc, wir, wreg, la, lb, lc, lf, s, rm, rs, aop, sop, pcs, rd, aa, ab};
    endfunction

    // EXEC pattern: LF=1 plus the instruction-dependent ALU/shifter fields.
    function automatic logic [22:0] ex(input logic s, rm, input logic [1:0] rs,
                                       input logic [3:0] aop, input logic [2:0] sop);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s, rm, rs, aop, sop,
                  2'b00, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [2:0] es, input logic [22:0] ev);
        vec++;
        assert ({state, ctl} === {es, ev}) else begin
            miss++;
            $error("FAIL %s: observed state=%0d ctl=%h, expected state=%0d ctl=%h", tag, state, ctl, es, ev);
        end
    endtask

    task automatic chk_nb(input string tag, input logic [2:0] es, input logic [22:0] ev);
        vec++;
        assert ({n_state, n_ctl} === {es, ev}) else begin
            miss++;
            $error("FAIL %s: observed state=%0d ctl=%h, expected state=%0d ctl=%h", tag, n_state, n_ctl, es, ev);
        end
    endtask

    task automatic cyc(input string tag, input logic [2:0] es, input logic [22:0] ev);
        @(posedge clk);
        #1;
        chk(tag, es, ev);
    endtask

    initial begin
        logic [22:0] zv, fetch_v, dec_v, wb_v, br_v, link_v, lwb_v;
        zv      = 23'd0;
        fetch_v = pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        dec_v   = pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        wb_v    = pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        br_v    = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0);
        link_v  = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 3'b000, 2'b00, 1'b0, 1'b1, 1'b1);
        lwb_v   = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 3'b000, 2'b01, 1'b1, 1'b0, 1'b0);

        Rst  = 1'b1;
        I    = 32'h0000_0000;
        NZCV = 4'b0000;
        cyc("rst_a", 3'd0, zv);
        cyc("rst_b", 3'd0, zv);
        chk_nb("nb_rst", 3'd0, zv);

        // ADD R1,R2,R3: 4 cycles FETCH..FETCH
        Rst = 1'b0;
        I   = 32'hE082_1003;
        chk("idle", 3'd0, zv);
        cyc("fetch0", 3'd1, fetch_v);
        cyc("add_dec", 3'd2, dec_v);
        cyc("add_exec", 3'd3, ex(1'b0, 1'b0, 2'b01, 4'b0100, 3'b000));
        cyc("add_wb", 3'd4, wb_v);
        cyc("add_fetch", 3'd1, fetch_v);

        // CMP R1,#5: no write-back
        I = 32'hE351_0005;
        cyc("cmp_dec", 3'd2, dec_v);
        cyc("cmp_exec", 3'd3, ex(1'b1, 1'b1, 2'b10, 4'b1010, 3'b111));
        cyc("cmp_fetch", 3'd1, fetch_v);

        // BEQ taken, then not taken
        I    = 32'h0A00_0003;
        NZCV = 4'b0100;
        cyc("beq_t_dec", 3'd2, dec_v);
        cyc("beq_t_br", 3'd7, br_v);
        cyc("beq_t_fetch", 3'd1, fetch_v);
        NZCV = 4'b0000;
        cyc("beq_n_dec", 3'd2, dec_v);
        cyc("beq_n_fetch", 3'd1, fetch_v);

        // BNE with Z=1 fails; BGT with N=V, Z=0 passes; cond 1111 never
        I    = 32'h1A00_0003;
        NZCV = 4'b0100;
        cyc("bne_dec", 3'd2, dec_v);
        cyc("bne_fetch", 3'd1, fetch_v);
        I    = 32'hCA00_0003;
        NZCV = 4'b1001;
        cyc("bgt_dec", 3'd2, dec_v);
        cyc("bgt_br", 3'd7, br_v);
        cyc("bgt_fetch", 3'd1, fetch_v);
        I    = 32'hFA00_0003;
        NZCV = 4'b0000;
        cyc("nv_dec", 3'd2, dec_v);
        cyc("nv_fetch", 3'd1, fetch_v);

        // ADD R1,R2,R2,ASR R3: register-specified shift
        I = 32'hE082_1352;
        cyc("rsr_dec", 3'd2, dec_v);
        cyc("rsr_exec", 3'd3, ex(1'b0, 1'b0, 2'b00, 4'b0100, 3'b101));
        cyc("rsr_wb", 3'd4, wb_v);
        cyc("rsr_fetch", 3'd1, fetch_v);

        // LDR (unsupported) and MUL (illegal DP) both run as 2-cycle NOPs
        I = 32'hE591_2000;
        cyc("ldr_dec", 3'd2, dec_v);
        cyc("ldr_fetch", 3'd1, fetch_v);
        I = 32'hE001_0392;
        cyc("mul_dec", 3'd2, dec_v);
        cyc("mul_fetch", 3'd1, fetch_v);
        chk_nb("nb_sync", 3'd1, fetch_v);

        // BL: link path on EN_BL=1, plain branch on EN_BL=0
        I = 32'hEB00_0010;
        cyc("bl_dec", 3'd2, dec_v);
        chk_nb("nb_bl_dec", 3'd2, dec_v);
        cyc("bl_link", 3'd5, link_v);
        chk_nb("nb_bl_br", 3'd7, br_v);
        cyc("bl_link_wb", 3'd6, lwb_v);
        chk_nb("nb_bl_fetch", 3'd1, fetch_v);
        Rst = 1'b1;
        cyc("bl_rst", 3'd0, zv);
        chk_nb("nb_bl_rst", 3'd0, zv);

        // Reset during EXEC of ADD: abandoned with no register write
        Rst = 1'b0;
        I   = 32'hE082_1003;
        cyc("mid_fetch", 3'd1, fetch_v);
        cyc("mid_dec", 3'd2, dec_v);
        cyc("mid_exec", 3'd3, ex(1'b0, 1'b0, 2'b01, 4'b0100, 3'b000));
        Rst = 1'b1;
        cyc("mid_rst", 3'd0, zv);
        cyc("mid_rst_hold", 3'd0, zv);
        Rst = 1'b0;
        cyc("mid_refetch", 3'd1, fetch_v);
        chk_nb("nb_refetch", 3'd1, fetch_v);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
